// File: rtl/dma_pkg.sv
// Shared constants and state encoding for the DMA device-side port.
package dma_pkg;

  localparam int ADD_LEN_DEF         = 16;
  localparam int DATA_LEN_DEF        = 16;
  localparam int SKID_DEPTH_LOG2_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_XFER  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } dma_state_e;

  localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;

endpackage

// File: rtl/dma_skid_buf.sv
// Small FIFO absorbing read words that arrive after dev_ack has fallen.
// The overflow checker is compiled only when SIM is defined.
module dma_skid_buf #(
  parameter int DATA_LEN   = 16,
  parameter int DEPTH_LOG2 = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_LEN-1:0]   push_data,
  input  logic                  pop,
  output logic [DATA_LEN-1:0]   pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);

  logic [DATA_LEN-1:0]   mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CNT_FULL);
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage, pointers and occupancy; a push into a full buffer is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_LEN{1'b0}};
      end
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef SIM
  dma_skid_buf_chk u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (do_pop_s),
    .full    (full)
  );
`endif

endmodule

`ifdef SIM
module dma_skid_buf_chk (
  input logic clk,
  input logic reset_n,
  input logic push,
  input logic pop,
  input logic full
);
  // A word arriving with no room means dev_ack was raised too eagerly.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(push && full && !pop))
        else $error("skid buffer overflow");
    end
  end
endmodule
`endif

// File: rtl/dma_dev_port.sv
// Device-side DMA front end: descriptor handoff, write-data feed, read-data skid capture.
// Optional watchdog is enabled by defining DMA_DEV_TIMEOUT_EN.
module dma_dev_port
  import dma_pkg::*;
#(
  parameter int ADD_LEN         = ADD_LEN_DEF,
  parameter int DATA_LEN        = DATA_LEN_DEF,
  parameter int SKID_DEPTH_LOG2 = SKID_DEPTH_LOG2_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rd_wr,
  input  logic [ADD_LEN-1:0]  cmd_num_words,
  input  logic [ADD_LEN:0]    cmd_start_addr,
  input  logic                src_valid,
  input  logic [DATA_LEN-1:0] src_data,
  output logic                src_ready,
  output logic                snk_valid,
  output logic [DATA_LEN-1:0] snk_data,
  input  logic                snk_ready,
  output logic                rqst,
  output logic                rd_wr,
  output logic [ADD_LEN-1:0]  num_words,
  output logic [ADD_LEN:0]    start_addr,
  output logic                dev_ack,
  output logic [DATA_LEN-1:0] dev_in,
  input  logic                dma_ack,
  input  logic [DATA_LEN-1:0] dev_out,
  input  logic                end_flag,
  input  logic                error_flag,
  output logic                done,
  output logic                err,
  output logic [ADD_LEN-1:0]  words_done
);

  localparam int CW = SKID_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [ADD_LEN-1:0] WD_ONE  = ADD_LEN'(1);

  dma_state_e          state_r;
  dma_state_e          state_nxt;
  logic                rd_wr_r;
  logic [ADD_LEN-1:0]  num_words_r;
  logic [ADD_LEN:0]    start_addr_r;
  logic [ADD_LEN-1:0]  words_done_r;
  logic                err_r;

  logic                accept_s;
  logic                is_xfer_s;
  logic                is_drain_s;
  logic                wr_xfer_s;
  logic                rd_xfer_s;
  logic                push_s;
  logic                pop_s;
  logic                full_s;
  logic                empty_s;
  logic [CW-1:0]       count_s;
  logic                drain_need_s;
  logic                wd_expired_s;
  logic                timeout_hit_s;
  logic                err_set_s;

  assign accept_s   = (state_r == ST_IDLE) & cmd_valid;
  assign is_xfer_s  = (state_r == ST_XFER);
  assign is_drain_s = (state_r == ST_DRAIN);
  assign wr_xfer_s  = is_xfer_s & ~rd_wr_r;
  assign rd_xfer_s  = is_xfer_s & rd_wr_r;
  assign push_s     = rd_xfer_s & dma_ack;
  assign pop_s      = ~empty_s & snk_ready;

  // Occupancy after this cycle's push/pop decides whether a read must drain.
  assign drain_need_s = push_s | ~(empty_s | ((count_s == CNT_ONE) & pop_s));

  dma_skid_buf #(
    .DATA_LEN   (DATA_LEN),
    .DEPTH_LOG2 (SKID_DEPTH_LOG2)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (timeout_hit_s),
    .push      (push_s),
    .push_data (dev_out),
    .pop       (pop_s),
    .pop_data  (snk_data),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

`ifdef DMA_DEV_TIMEOUT_EN
  logic [15:0] wdog_r;

  // Idle-cycle watchdog, restarted by any controller activity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_r <= 16'd0;
    end else if (is_xfer_s | is_drain_s) begin
      if (dma_ack | end_flag) begin
        wdog_r <= 16'd0;
      end else if (wdog_r != WDOG_LIMIT) begin
        wdog_r <= wdog_r + 16'd1;
      end else begin
        wdog_r <= wdog_r;
      end
    end else begin
      wdog_r <= 16'd0;
    end
  end

  assign wd_expired_s = (wdog_r == WDOG_LIMIT);
`else
  assign wd_expired_s = 1'b0;
`endif

  // Normal completion takes priority over an expiring watchdog.
  assign timeout_hit_s = wd_expired_s & ((is_xfer_s & ~end_flag) | (is_drain_s & ~empty_s));
  assign err_set_s     = (is_xfer_s & error_flag) | (push_s & full_s & ~pop_s) | timeout_hit_s;

  assign cmd_ready  = (state_r == ST_IDLE);
  assign rqst       = (state_r == ST_REQ);
  assign done       = (state_r == ST_DONE);
  assign rd_wr      = rd_wr_r;
  assign num_words  = num_words_r;
  assign start_addr = start_addr_r;
  assign err        = err_r;
  assign words_done = words_done_r;
  assign snk_valid  = ~empty_s;
  assign src_ready  = wr_xfer_s & dma_ack;
  assign dev_in     = wr_xfer_s ? src_data : {DATA_LEN{1'b0}};

  // Read side accepts only when a late word still has a free slot.
  always_comb begin
    dev_ack = 1'b0;
    if (wr_xfer_s) begin
      dev_ack = src_valid;
    end else if (rd_xfer_s) begin
      dev_ack = empty_s | ((count_s == CNT_ONE) & snk_ready);
    end else begin
      dev_ack = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt = ST_REQ;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REQ: state_nxt = ST_XFER;
      ST_XFER: begin
        if (end_flag) begin
          if (rd_wr_r && drain_need_s) begin
            state_nxt = ST_DRAIN;
          end else begin
            state_nxt = ST_DONE;
          end
        end else if (timeout_hit_s) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_XFER;
        end
      end
      ST_DRAIN: begin
        if (empty_s || timeout_hit_s) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, descriptor, progress and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      rd_wr_r      <= 1'b0;
      num_words_r  <= {ADD_LEN{1'b0}};
      start_addr_r <= {(ADD_LEN+1){1'b0}};
      words_done_r <= {ADD_LEN{1'b0}};
      err_r        <= 1'b0;
    end else begin
      state_r <= state_nxt;
      if (accept_s) begin
        rd_wr_r      <= cmd_rd_wr;
        num_words_r  <= cmd_num_words;
        start_addr_r <= cmd_start_addr;
        words_done_r <= {ADD_LEN{1'b0}};
        err_r        <= 1'b0;
      end else begin
        if (is_xfer_s && dma_ack) begin
          words_done_r <= words_done_r + WD_ONE;
        end
        if (err_set_s) begin
          err_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_dev_port.sv
// Directed bench for dma_dev_port: a transaction-level model checked every cycle
// plus literal expectations per scenario. Define DMA_DEV_TIMEOUT_EN to add the watchdog case.
module tb_dma_dev_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_rd_wr;
  logic [15:0] cmd_num_words;
  logic [16:0] cmd_start_addr;
  logic        src_valid, src_ready;
  logic [15:0] src_data;
  logic        snk_valid, snk_ready;
  logic [15:0] snk_data;
  logic        rqst, rd_wr;
  logic [15:0] num_words;
  logic [16:0] start_addr;
  logic        dev_ack;
  logic [15:0] dev_in;
  logic        dma_ack;
  logic [15:0] dev_out;
  logic        end_flag, error_flag, done, err;
  logic [15:0] words_done;

  dma_dev_port dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
    .cmd_num_words(cmd_num_words), .cmd_start_addr(cmd_start_addr),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
    .rqst(rqst), .rd_wr(rd_wr), .num_words(num_words), .start_addr(start_addr),
    .dev_ack(dev_ack), .dev_in(dev_in), .dma_ack(dma_ack), .dev_out(dev_out),
    .end_flag(end_flag), .error_flag(error_flag), .done(done), .err(err),
    .words_done(words_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model, checked just before each rising edge
  bit          m_busy, m_rqst, m_xfer, m_drain, m_done, m_rd, m_err;
  logic [15:0] m_words, m_nw;
  logic [16:0] m_addr;
  logic [15:0] m_q[$];
  int          m_wd;

  always begin
    bit pre_busy, pop, in_xd, wd_exp, exp_ack;
    int qs_pre;
    @(negedge clk);
    #4;
    if (!reset_n) begin
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rqst", rqst, 0);
      chk("rst_dev_ack", dev_ack, 0);
      chk("rst_snk_valid", snk_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_words_done", words_done, 0);
      chk("rst_num_words", num_words, 0);
      chk("rst_start_addr", start_addr, 0);
      chk("rst_src_ready", src_ready, 0);
      m_busy = 0; m_rqst = 0; m_xfer = 0; m_drain = 0; m_done = 0; m_rd = 0;
      m_err = 0; m_words = 16'd0; m_nw = 16'd0; m_addr = 17'd0; m_q.delete(); m_wd = 0;
    end else begin
      qs_pre = m_q.size();
      exp_ack = 0;
      if (m_xfer) exp_ack = m_rd ? (qs_pre == 0 || (qs_pre == 1 && snk_ready)) : src_valid;
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("rqst", rqst, m_rqst);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("words_done", words_done, m_words);
      chk("dev_ack", dev_ack, exp_ack);
      chk("src_ready", src_ready, m_xfer && !m_rd && dma_ack);
      chk("snk_valid", snk_valid, qs_pre != 0);
      if (qs_pre != 0) chk("snk_data", snk_data, m_q[0]);
      if (m_xfer && !m_rd) chk("dev_in", dev_in, src_data);
      if (m_xfer && m_rd && qs_pre == 2) chk("dev_ack_full", dev_ack, 0);
      if (m_busy) begin
        chk("rd_wr", rd_wr, m_rd);
        chk("num_words", num_words, m_nw);
        chk("start_addr", start_addr, m_addr);
      end
`ifdef DMA_DEV_TIMEOUT_EN
      wd_exp = (m_wd == 65535);
`else
      wd_exp = 0;
`endif
      in_xd    = m_xfer || m_drain;
      pre_busy = m_busy;
      pop      = (qs_pre != 0) && snk_ready;
      if (pop) void'(m_q.pop_front());
      if (m_xfer && dma_ack) begin
        m_words = m_words + 16'd1;
        if (m_rd) m_q.push_back(dev_out);
      end
      if (m_xfer && error_flag) m_err = 1;
      if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (m_drain) begin
        if (qs_pre == 0) begin m_drain = 0; m_done = 1; end
        else if (wd_exp) begin m_drain = 0; m_done = 1; m_err = 1; m_q.delete(); end
      end else if (m_xfer) begin
        if (end_flag) begin
          m_xfer = 0;
          if (m_rd && m_q.size() != 0) m_drain = 1; else m_done = 1;
        end else if (wd_exp) begin
          m_xfer = 0; m_done = 1; m_err = 1; m_q.delete();
        end
      end else if (m_rqst) begin
        m_rqst = 0; m_xfer = 1;
      end else if (!pre_busy && cmd_valid) begin
        m_busy = 1; m_rqst = 1; m_rd = cmd_rd_wr; m_nw = cmd_num_words;
        m_addr = cmd_start_addr; m_err = 0; m_words = 16'd0;
      end
      if (in_xd) m_wd = (dma_ack || end_flag) ? 0 : ((m_wd < 65535) ? m_wd + 1 : m_wd);
      else m_wd = 0;
    end
  end

  // ---------------- stimulus: peripheral source/sink plus a simple DMA controller
  logic [15:0] got_q[$];
  logic [15:0] dma_rx[$];
  int          rqst_cyc, done_cyc, last_ack_cyc, src_cnt;
  logic [16:0] rq_addr;
  logic [15:0] rq_nw;

  // snk_mode: 0 always ready, 1 toggling, 2 never ready. rst_cyc>0 pulls reset mid-run.
  task automatic run_xfer(input bit rd, input int n, input logic [16:0] addr,
                          input logic [15:0] base, input int gap, input int snk_mode,
                          input int err_after, input int rst_cyc, input bit stall,
                          input int budget);
    int sent = 0, cyc = 0, gap_cnt = 0, src_idx = 0, sent_pre;
    bit active = 0, prev_ack = 0, got_done = 0, end_sent = 0, err_sent = 0;
    got_q.delete(); dma_rx.delete();
    rqst_cyc = -1; done_cyc = -1; last_ack_cyc = -1; src_cnt = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rd_wr = rd; cmd_num_words = n[15:0]; cmd_start_addr = addr;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!got_done && cyc < budget) begin
      src_valid = !rd && (gap_cnt == 0) && (src_idx < n);
      src_data  = base + src_idx[15:0];
      snk_ready = (snk_mode == 0) ? 1'b1 : (snk_mode == 1) ? cyc[0] : 1'b0;
      dma_ack = 1'b0; end_flag = 1'b0; error_flag = 1'b0;
      #1;
      if (active && !stall) begin
        sent_pre = sent;
        if (rd) begin
          if (prev_ack && sent < n) begin dma_ack = 1'b1; dev_out = base + sent[15:0]; sent++; end
        end else begin
          if (dev_ack && sent < n) begin dma_ack = 1'b1; sent++; end
        end
        if (sent == n && !end_sent) begin end_flag = 1'b1; end_sent = 1; end
        if (err_after > 0 && !err_sent && sent_pre == err_after) begin error_flag = 1'b1; err_sent = 1; end
      end
      if (rst_cyc > 0 && cyc == rst_cyc) begin
        dma_ack = 1'b0; end_flag = 1'b0; reset_n = 1'b0;
        #1;
        chk("rst_now_rqst", rqst, 0);
        chk("rst_now_dev_ack", dev_ack, 0);
        chk("rst_now_snk_valid", snk_valid, 0);
        chk("rst_now_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      #2;
      if (!rd && src_ready) begin src_cnt++; src_idx++; gap_cnt = gap; end
      else if (gap_cnt > 0) gap_cnt--;
      if (!rd && dma_ack) begin dma_rx.push_back(dev_in); last_ack_cyc = cyc; end
      if (rd && snk_valid && snk_ready) got_q.push_back(snk_data);
      if (rqst) begin active = 1; rqst_cyc = cyc; rq_addr = start_addr; rq_nw = num_words; end
      if (done) begin got_done = 1; done_cyc = cyc; end
      prev_ack = dev_ack;
      cyc++;
      @(negedge clk);
    end
    src_valid = 1'b0; snk_ready = 1'b0; dma_ack = 1'b0; end_flag = 1'b0; error_flag = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    logic [15:0] exp_w;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_rd_wr = 1'b0; cmd_num_words = 16'd0;
    cmd_start_addr = 17'd0; src_valid = 1'b0; src_data = 16'd0; snk_ready = 1'b0;
    dma_ack = 1'b0; dev_out = 16'd0; end_flag = 1'b0; error_flag = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // 1: write 4 words, source always ready
    run_xfer(0, 4, 17'h0200, 16'hA001, 0, 0, 0, 0, 0, 200);
    chk("t1_rqst_cyc", rqst_cyc, 0);
    chk("t1_rq_addr", rq_addr, 17'h0200);
    chk("t1_rq_nw", rq_nw, 4);
    chk("t1_done_cyc", done_cyc, 5);
    chk("t1_src_cnt", src_cnt, 4);
    chk("t1_rx_cnt", dma_rx.size(), 4);
    for (int i = 0; i < 4 && i < dma_rx.size(); i++) begin
      exp_w = 16'hA001 + i[15:0];
      chk("t1_rx_data", dma_rx[i], exp_w);
    end
    #4;
    chk("t1_words_done", words_done, 4);
    chk("t1_err", err, 0);

    // 2: read 6 words, sink ready toggling
    run_xfer(1, 6, 17'h0300, 16'hB001, 0, 1, 0, 0, 0, 200);
    chk("t2_rq_addr", rq_addr, 17'h0300);
    chk("t2_rd_wr", rd_wr, 1);
    chk("t2_got_cnt", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      exp_w = 16'hB001 + i[15:0];
      chk("t2_got_data", got_q[i], exp_w);
    end
    #4;
    chk("t2_words_done", words_done, 6);

    // 3: write 5 words with 3-cycle source gaps
    run_xfer(0, 5, 17'h0400, 16'hC001, 3, 0, 0, 0, 0, 200);
    chk("t3_src_cnt", src_cnt, 5);
    chk("t3_rx_cnt", dma_rx.size(), 5);
    for (int i = 0; i < 5 && i < dma_rx.size(); i++) begin
      exp_w = 16'hC001 + i[15:0];
      chk("t3_rx_data", dma_rx[i], exp_w);
    end
    chk("t3_done_after_ack", done_cyc - last_ack_cyc, 1);
    #4;
    chk("t3_words_done", words_done, 5);

    // 4: zero-length read
    run_xfer(1, 0, 17'h0500, 16'h0000, 0, 0, 0, 0, 0, 50);
    chk("t4_done_lat", done_cyc - rqst_cyc, 2);
    chk("t4_got_cnt", got_q.size(), 0);
    #4;
    chk("t4_words_done", words_done, 0);
    chk("t4_err", err, 0);

    // 5: read 4 words with error_flag after word 2
    run_xfer(1, 4, 17'h0600, 16'hE001, 0, 0, 2, 0, 0, 200);
    chk("t5_got_cnt", got_q.size(), 4);
    #4;
    chk("t5_err", err, 1);
    chk("t5_words_done", words_done, 4);
    repeat (3) @(negedge clk);
    #4;
    chk("t5_err_sticky", err, 1);

    // 6: next command clears err
    run_xfer(0, 2, 17'h0700, 16'hD001, 0, 0, 0, 0, 0, 200);
    #4;
    chk("t6_err_cleared", err, 0);
    chk("t6_words_done", words_done, 2);

    // 7: reset while a read still has words outstanding
    run_xfer(1, 6, 17'h0800, 16'hF001, 0, 2, 0, 5, 0, 200);
    #4;
    chk("t7_cmd_ready_after", cmd_ready, 1);
    chk("t7_words_done_after", words_done, 0);

`ifdef DMA_DEV_TIMEOUT_EN
    // 8: controller never acknowledges
    run_xfer(1, 2, 17'h0900, 16'h1001, 0, 0, 0, 0, 1, 70000);
    chk("t8_timeout_lat", done_cyc - rqst_cyc, 65537);
    #4;
    chk("t8_err", err, 1);
    chk("t8_cmd_ready", cmd_ready, 1);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
